mmio_fifo_afu: RTL and testbench

MMIO_FIFO_AFU -- requirements
Module: mmio_fifo_afu

---
 rtl/mmio_fifo_pkg.sv | 97 +++++++++
 rtl/mmio_fifo_buf.sv | 60 ++++++
 rtl/mmio_fifo_afu.sv | 117 +++++++++++
 tb/tb_mmio_fifo_afu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// Shared types and register map for the MMIO FIFO AFU: minimal CCI-P channel
// structs, register offsets, STATUS/ERR/CTRL bit positions and AFU identity.
package mmio_fifo_pkg;

    localparam int unsigned CCIP_DATA_W = 512;
    localparam int unsigned MMIO_DATA_W = 64;
    localparam int unsigned TID_W       = 9;
    localparam int unsigned MMIO_ADDR_W = 16;

    typedef logic [TID_W-1:0]       t_ccip_tid;
    typedef logic [MMIO_ADDR_W-1:0] t_ccip_mmioAddr;
    typedef logic [73:0]            t_ccip_c0_ReqMemHdr;
    typedef logic [79:0]            t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_mmioAddr address;
        logic [1:0]     length;
        logic           rsvd;
        t_ccip_tid      tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr     hdr;
        logic [CCIP_DATA_W-1:0] data;
        logic                   rspValid;
        logic                   mmioRdValid;
        logic                   mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr     hdr;
        logic [CCIP_DATA_W-1:0] data;
        logic                   valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr    hdr;
        logic                   mmioRdValid;
        logic [MMIO_DATA_W-1:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // Register offsets in CCI-P MMIO (32-bit word) address units
    localparam t_ccip_mmioAddr ADDR_DFH      = 16'h0000;
    localparam t_ccip_mmioAddr ADDR_AFU_ID_L = 16'h0002;
    localparam t_ccip_mmioAddr ADDR_AFU_ID_H = 16'h0004;
    localparam t_ccip_mmioAddr ADDR_DFH_RSV0 = 16'h0006;
    localparam t_ccip_mmioAddr ADDR_DFH_RSV1 = 16'h0008;
    localparam t_ccip_mmioAddr ADDR_DATA     = 16'h0020;
    localparam t_ccip_mmioAddr ADDR_STATUS   = 16'h0022;
    localparam t_ccip_mmioAddr ADDR_ERR      = 16'h0024;
    localparam t_ccip_mmioAddr ADDR_CTRL     = 16'h0026;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_CNT_LSB   = 8;
    localparam int unsigned STATUS_CNT_W     = 8;
    localparam int unsigned ERR_OVF_LSB      = 0;
    localparam int unsigned ERR_UNF_LSB      = 32;
    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_BIT     = 1;

    // DFH: feature type AFU in [63:60], end-of-list in [40]
    localparam logic [63:0]  DFH_AFU = {4'b0001, 19'd0, 1'b1, 40'd0};
    localparam logic [127:0] AFU_ID  = 128'h9F3C_2A71_5D48_4E0B_B6C1_0E27_4A93_D015;

endpackage

// File: rtl/mmio_fifo_buf.sv
// FIFO storage with wrapping pointers and a separate occupancy count.
// Head entry is presented combinationally so the caller can register it.
module mmio_fifo_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign w_do_push = push && !flush && !rst && (!full || pop);
    assign w_do_pop  = pop  && !flush && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/mmio_fifo_afu.sv
// CCI-P AFU exposing a FIFO over MMIO: DFH/ID registers, DATA push/pop,
// STATUS, saturating error counters and a CTRL flush/clear register.
module mmio_fifo_afu
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  t_if_ccip_Rx rx,
    output t_if_ccip_Tx tx
);
    localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

    t_ccip_c0_ReqMmioHdr w_hdr;
    logic                w_rd;
    logic                w_wr;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_clr;
    logic                w_ovf;
    logic                w_unf;
    logic                w_full;
    logic                w_empty;
    logic [DATA_W-1:0]   w_dout;
    logic [FCNT_W-1:0]   w_count;
    logic [63:0]         w_rd_data;
    logic [CNT_W-1:0]    r_ovf_cnt;
    logic [CNT_W-1:0]    r_unf_cnt;
    t_if_ccip_c2_Tx      r_c2;
    logic                w_unused;

    assign w_hdr   = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
    assign w_rd    = rx.c0.mmioRdValid;
    assign w_wr    = rx.c0.mmioWrValid;
    assign w_push  = w_wr && (w_hdr.address == ADDR_DATA);
    assign w_pop   = w_rd && (w_hdr.address == ADDR_DATA);
    assign w_flush = w_wr && (w_hdr.address == ADDR_CTRL) && rx.c0.data[CTRL_FLUSH_BIT];
    assign w_clr   = w_wr && (w_hdr.address == ADDR_CTRL) && rx.c0.data[CTRL_CLR_BIT];
    // A simultaneous pop frees the slot, so only a lone push into full overflows
    assign w_ovf   = w_push && w_full && !w_pop && !w_flush;
    assign w_unf   = w_pop && w_empty && !w_flush;

    assign w_unused = ^{rx.c0TxAlmFull, rx.c1TxAlmFull, rx.c0.rspValid,
                        w_hdr.length, w_hdr.rsvd, rx.c0.data};

    mmio_fifo_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (rx.c0.data[DATA_W-1:0]),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Read mux: every field reflects state before this cycle's update
    always_comb begin
        w_rd_data = '0;
        case (w_hdr.address)
            ADDR_DFH:      w_rd_data = DFH_AFU;
            ADDR_AFU_ID_L: w_rd_data = AFU_ID[63:0];
            ADDR_AFU_ID_H: w_rd_data = AFU_ID[127:64];
            ADDR_DATA:     w_rd_data = w_empty ? 64'd0 : 64'(w_dout);
            ADDR_STATUS: begin
                w_rd_data[STATUS_EMPTY_BIT] = w_empty;
                w_rd_data[STATUS_FULL_BIT]  = w_full;
                w_rd_data[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(w_count);
            end
            ADDR_ERR: begin
                w_rd_data[ERR_OVF_LSB +: CNT_W] = r_ovf_cnt;
                w_rd_data[ERR_UNF_LSB +: CNT_W] = r_unf_cnt;
            end
            default: w_rd_data = '0;
        endcase
    end

    // Saturating error counters
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else begin
            if (w_ovf && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
            if (w_unf && (r_unf_cnt != '1)) begin
                r_unf_cnt <= r_unf_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c2 <= '0;
        end else begin
            r_c2.mmioRdValid <= w_rd;
            r_c2.hdr.tid     <= w_hdr.tid;
            r_c2.data        <= w_rd_data;
        end
    end

    always_comb begin
        tx    = '0;
        tx.c2 = r_c2;
    end

endmodule

// File: tb/tb_mmio_fifo_afu.sv
// Randomized bench for mmio_fifo_afu: queue-based register model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mmio_fifo_afu;
    import mmio_fifo_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 40;
    localparam int unsigned CNT_W  = 4;
    localparam int          SAT    = 15;
    localparam logic [63:0]  DMASK      = 64'h0000_00FF_FFFF_FFFF;
    localparam logic [127:0] EXP_AFU_ID = 128'h9F3C_2A71_5D48_4E0B_B6C1_0E27_4A93_D015;
    localparam logic [63:0]  EXP_DFH    = 64'h1000_0100_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;

    always #5 clk = ~clk;

    mmio_fifo_afu #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] q[$];
    int          ovf = 0;
    int          unf = 0;
    bit          chk_en = 1'b0;
    logic        nxt_valid = 1'b0;
    logic [8:0]  nxt_tid = '0;
    logic [63:0] nxt_data = '0;
    logic        exp_valid;
    logic [8:0]  exp_tid;
    logic [63:0] exp_data;

    always @(posedge clk) begin
        exp_valid <= nxt_valid;
        exp_tid   <= nxt_tid;
        exp_data  <= nxt_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rdvalid", 64'(tx.c2.mmioRdValid), 64'(exp_valid));
            if (exp_valid) begin
                check("tid", 64'(tx.c2.hdr.tid), 64'(exp_tid));
                check("rddata", tx.c2.data, exp_data);
            end
            check("c0c1_valid", 64'({tx.c0.valid, tx.c1.valid}), 64'd0);
        end
    end

    // One MMIO cycle: drive the request and advance the behavioural model
    task automatic op(input bit do_rst, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [63:0] data, input logic [8:0] tid);
        t_ccip_c0_ReqMmioHdr h;
        logic [63:0]         rdv;
        int                  sz;
        @(posedge clk);
        #1;
        h = '0;
        h.address = addr;
        h.tid = tid;
        h.length = 2'($urandom());
        rst = do_rst;
        rx = '0;
        rx.c0TxAlmFull = 1'($urandom());
        rx.c0.hdr = t_ccip_c0_RspMemHdr'(h);
        rx.c0.mmioRdValid = rd;
        rx.c0.mmioWrValid = wr;
        rx.c0.data[63:0] = data;
        rx.c0.data[511:448] = {$urandom(), $urandom()};
        if (do_rst) begin
            q.delete();
            ovf = 0;
            unf = 0;
            nxt_valid = 1'b0;
            return;
        end
        rdv = '0;
        sz = q.size();
        if (rd) begin
            case (addr)
                16'h0000: rdv = EXP_DFH;
                16'h0002: rdv = EXP_AFU_ID[63:0];
                16'h0004: rdv = EXP_AFU_ID[127:64];
                16'h0020: begin
                    if (sz == 0) begin
                        rdv = '0;
                        if (unf < SAT) unf++;
                    end else begin
                        rdv = q.pop_front();
                    end
                end
                16'h0022: rdv = (64'(sz) << 8) | (64'(sz == DEPTH) << 1) | 64'(sz == 0);
                16'h0024: rdv = (64'(unf) << 32) | 64'(ovf);
                default:  rdv = '0;
            endcase
        end
        if (wr) begin
            case (addr)
                16'h0020: begin
                    if (q.size() < DEPTH) q.push_back(data & DMASK);
                    else if (ovf < SAT) ovf++;
                end
                16'h0026: begin
                    if (data[0]) q.delete();
                    if (data[1]) begin
                        ovf = 0;
                        unf = 0;
                    end
                end
                default: ;
            endcase
        end
        nxt_valid = rd;
        nxt_tid = tid;
        nxt_data = rdv;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] data);
        op(1'b0, 1'b0, 1'b1, addr, data, 9'h0);
    endtask

    task automatic reset_dut();
        op(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
        idle();
    endtask

    // Read with a literal expectation on the returned data
    task automatic rd_lit(input string name, input logic [15:0] addr, input logic [8:0] tid,
                          input logic [63:0] exp);
        op(1'b0, 1'b1, 1'b0, addr, 64'h0, tid);
        idle();
        @(negedge clk);
        check(name, tx.c2.data, exp);
    endtask

    initial begin
        logic [15:0] rd_addrs [7];
        logic [15:0] ro_addrs [4];
        int          bias;
        rd_addrs = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008, 16'h0026, 16'h0021};
        ro_addrs = '{16'h0000, 16'h0002, 16'h0022, 16'h0024};
        bias = 50;
        rst = 1'b1;
        rx = '0;

        reset_dut();
        @(negedge clk);
        check("rst_valid", 64'(tx.c2.mmioRdValid), 64'd0);
        check("rst_data", tx.c2.data, 64'd0);
        check("rst_tid", 64'(tx.c2.hdr.tid), 64'd0);
        chk_en = 1'b1;
        rd_lit("rst_status", 16'h0022, 9'h0, 64'h1);
        rd_lit("rst_err", 16'h0024, 9'h0, 64'h0);
        rd_lit("dfh", 16'h0000, 9'h3, EXP_DFH);
        rd_lit("afu_id_lo", 16'h0002, 9'h4, EXP_AFU_ID[63:0]);

        wr(16'h0020, 64'hA);
        wr(16'h0020, 64'hB);
        wr(16'h0020, 64'hC);
        rd_lit("s29_pop0", 16'h0020, 9'h1, 64'hA);
        rd_lit("s29_pop1", 16'h0020, 9'h2, 64'hB);
        rd_lit("s29_pop2", 16'h0020, 9'h3, 64'hC);
        rd_lit("s29_status", 16'h0022, 9'h4, 64'h1);

        for (int i = 0; i < 9; i++) wr(16'h0020, 64'(32'h11 + i));
        rd_lit("s30_status", 16'h0022, 9'h5, 64'h0802);
        rd_lit("s30_err_ovf", 16'h0024, 9'h6, 64'h1);
        for (int i = 0; i < 8; i++) rd_lit("s30_pop", 16'h0020, 9'(i), 64'(32'h11 + i));
        rd_lit("s30_pop_empty", 16'h0020, 9'h7, 64'h0);
        rd_lit("s30_err_unf", 16'h0024, 9'h8, 64'h1_0000_0001);

        for (int i = 0; i < 3; i++) wr(16'h0020, 64'(32'h70 + i));
        wr(16'h0026, 64'h3);
        rd_lit("s31_status", 16'h0022, 9'h9, 64'h1);
        rd_lit("s31_err", 16'h0024, 9'hA, 64'h0);
        rd_lit("s31_pop", 16'h0020, 9'hB, 64'h0);
        rd_lit("s31_err_unf", 16'h0024, 9'hC, 64'h1_0000_0000);

        for (int i = 0; i < 20; i++) begin
            wr(16'h0020, 64'(32'hC0DE_0000 + i));
            rd_lit("s32_status", 16'h0022, 9'(i), 64'h100);
            rd_lit("s32_pop", 16'h0020, 9'(i), 64'(32'hC0DE_0000 + i));
        end

        rd_lit("s33_data", 16'h0004, 9'h1A5, EXP_AFU_ID[127:64]);
        check("s33_tid", 64'(tx.c2.hdr.tid), 64'h1A5);
        check("s33_valid", 64'(tx.c2.mmioRdValid), 64'd1);
        idle();
        @(negedge clk);
        check("s33_valid_drop", 64'(tx.c2.mmioRdValid), 64'd0);

        for (int i = 0; i < 4; i++) wr(16'h0020, 64'(32'h90 + i));
        op(1'b1, 1'b1, 1'b0, 16'h0020, 64'h0, 9'h55);
        idle();
        @(negedge clk);
        check("s34_no_rsp", 64'(tx.c2.mmioRdValid), 64'd0);
        rd_lit("s34_status", 16'h0022, 9'h1, 64'h1);
        rd_lit("s34_err", 16'h0024, 9'h2, 64'h0);
        op(1'b0, 1'b1, 1'b0, 16'h0022, 64'h0, 9'h77);
        reset_dut();

        for (int n = 0; n < 4000; n++) begin
            int          k;
            int          s;
            logic [63:0] d;
            logic [8:0]  t;
            logic [15:0] a;
            bit          r;
            if (n % 250 == 0) bias = 15 + 35 * $urandom_range(0, 2);
            d = {$urandom(), $urandom()};
            t = 9'($urandom());
            r = 1'($urandom());
            k = $urandom_range(0, 999);
            if (k < 3) begin
                op(1'b1, r, 1'b0, 16'h0020, d, t);
            end else if (k < 700) begin
                s = $urandom_range(0, 99);
                if (s < 5)         op(1'b0, 1'b1, 1'b1, 16'h0020, d, t);
                else if (s < bias) op(1'b0, 1'b0, 1'b1, 16'h0020, d, t);
                else               op(1'b0, 1'b1, 1'b0, 16'h0020, d, t);
            end else if (k < 780) begin
                op(1'b0, 1'b1, 1'b0, 16'h0022, d, t);
            end else if (k < 840) begin
                op(1'b0, 1'b1, 1'b0, 16'h0024, d, t);
            end else if (k < 855) begin
                op(1'b0, 1'b0, 1'b1, 16'h0026, 64'($urandom_range(0, 3)), t);
            end else if (k < 920) begin
                op(1'b0, 1'b1, 1'b0, rd_addrs[$urandom_range(0, 6)], d, t);
            end else if (k < 950) begin
                idle();
            end else if (k < 975) begin
                op(1'b0, 1'b0, 1'b1, ro_addrs[$urandom_range(0, 3)], d, t);
            end else begin
                a = 16'($urandom_range(32'h0040, 32'hFFFF));
                op(1'b0, r, !r, a, d, t);
            end
        end
        idle();
        idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
